// File: rtl/crc_stream_appender.sv
// Streaming CRC appender: forwards each packet unchanged, then emits the final
// CRC as CRCWIDTH/DATAWIDTH extra words (most-significant word first).

module crc_calculator #(
    parameter int                   DATAWIDTH  = 8,
    parameter int                   CRCWIDTH   = 16,
    parameter logic [CRCWIDTH-1:0]  POLYNOMIAL = 16'h8005
) (
    input  logic [CRCWIDTH-1:0]  crc_i,
    input  logic [DATAWIDTH-1:0] dat_i,
    output logic [CRCWIDTH-1:0]  crc_o
);

    logic [CRCWIDTH-1:0] c;
    logic                fb;

    // Non-reflected shift register, data consumed MSB first.
    always_comb begin
        c  = crc_i;
        fb = 1'b0;
        for (int unsigned i = 0; i < DATAWIDTH; i++) begin
            fb = c[CRCWIDTH-1] ^ dat_i[DATAWIDTH-1-i];
            c  = {c[CRCWIDTH-2:0], 1'b0} ^ (fb ? POLYNOMIAL : '0);
        end
    end

    assign crc_o = c;

endmodule

module crc_stream_appender #(
    parameter int                   DATAWIDTH  = 8,
    parameter int                   CRCWIDTH   = 16,
    parameter logic [CRCWIDTH-1:0]  POLYNOMIAL = 16'h8005,
    parameter logic [CRCWIDTH-1:0]  INIT       = 16'h0000,
    parameter bit                   REFIN      = 1'b1,
    parameter bit                   REFOUT     = 1'b1,
    parameter logic [CRCWIDTH-1:0]  XOROUT     = 16'h0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATAWIDTH-1:0] i_dat,
    input  logic                 i_val,
    input  logic                 i_sop,
    input  logic                 i_eop,
    output logic                 o_rdy,
    output logic [DATAWIDTH-1:0] o_dat,
    output logic                 o_val,
    output logic                 o_sop,
    output logic                 o_eop,
    input  logic                 i_rdy,
    output logic                 o_err
);

    localparam int NWORDS = CRCWIDTH / DATAWIDTH;
    localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] APPEND = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [CRCWIDTH-1:0]  acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic [DATAWIDTH-1:0] dat_rev, dat_cond;
    logic [CRCWIDTH-1:0]  crc_seed, crc_next;
    logic [CRCWIDTH-1:0]  acc_rev, final_crc, crc_shift;
    logic [DATAWIDTH-1:0] app_word;

    logic                 rdy, val, sop, eop;
    logic [DATAWIDTH-1:0] dat;

    always_comb begin
        dat_rev = '0;
        for (int unsigned i = 0; i < DATAWIDTH; i++) dat_rev[i] = i_dat[DATAWIDTH-1-i];
    end

    always_comb begin
        acc_rev = '0;
        for (int unsigned i = 0; i < CRCWIDTH; i++) acc_rev[i] = acc_q[CRCWIDTH-1-i];
    end

    assign dat_cond  = REFIN ? dat_rev : i_dat;
    // A sop word always restarts from INIT, even when it arrives mid-packet.
    assign crc_seed  = (state_q == DATA && !i_sop) ? acc_q : INIT;
    assign final_crc = (REFOUT ? acc_rev : acc_q) ^ XOROUT;
    assign crc_shift = final_crc >> (DATAWIDTH * (NWORDS - 1 - int'(cnt_q)));
    assign app_word  = crc_shift[DATAWIDTH-1:0];

    crc_calculator #(
        .DATAWIDTH  (DATAWIDTH),
        .CRCWIDTH   (CRCWIDTH),
        .POLYNOMIAL (POLYNOMIAL)
    ) u_crc (
        .crc_i (crc_seed),
        .dat_i (dat_cond),
        .crc_o (crc_next)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        rdy     = 1'b0;
        val     = 1'b0;
        sop     = 1'b0;
        eop     = 1'b0;
        dat     = i_dat;
        case (state_q)
            IDLE: begin
                rdy = i_sop ? i_rdy : 1'b1;
                val = i_val & i_sop;
                sop = i_val & i_sop;
                if (i_val && rdy) begin
                    if (i_sop) begin
                        acc_d   = crc_next;
                        state_d = i_eop ? APPEND : DATA;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DATA: begin
                rdy = i_rdy;
                val = i_val;
                sop = i_val & i_sop;
                if (i_val && i_rdy) begin
                    acc_d = crc_next;
                    err_d = i_sop;
                    if (i_eop) state_d = APPEND;
                end
            end
            APPEND: begin
                val = 1'b1;
                dat = app_word;
                eop = (cnt_q == LAST);
                if (i_rdy) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are forced low while reset is held, independent of inputs.
    assign o_rdy = rdy & reset;
    assign o_val = val & reset;
    assign o_sop = sop & reset;
    assign o_eop = eop & reset;
    assign o_dat = dat;
    assign o_err = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= INIT;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: doc/crc_stream_appender.md
CRC_STREAM_APPENDER -- requirements
Module: crc_stream_appender

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATAWIDTH, 8, stream word width.
- CRCWIDTH, 16, CRC width; SHALL be an integer multiple of DATAWIDTH.
- POLYNOMIAL, 16'h8005, generator polynomial.
- INIT, 16'h0000, CRC register value at start of packet.
- REFIN, 1, 1 = bit-reverse each data word before CRC update.
- REFOUT, 1, 1 = bit-reverse final CRC.
- XOROUT, 16'h0000, value XORed onto final CRC.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state on rising edge.
- reset, in, 1, asynchronous active-low reset.
- i_dat, in, DATAWIDTH, input word.
- i_val, in, 1, input word valid.
- i_sop, in, 1, first word of packet.
- i_eop, in, 1, last word of packet.
- o_rdy, out, 1, block accepts input word.
- o_dat, out, DATAWIDTH, output word.
- o_val, out, 1, output word valid.
- o_sop, out, 1, output first word.
- o_eop, out, 1, output last word (last CRC word).
- i_rdy, in, 1, downstream accepts output word.
- o_err, out, 1, one-cycle framing-error pulse.
REQ-003 The CRC update SHALL use one crc_calculator instance (DATAWIDTH, CRCWIDTH, POLYNOMIAL) fed by the CRC accumulator register and the REFIN-conditioned input word.

Function
REQ-004 An input transfer SHALL occur on a cycle with i_val=1 and o_rdy=1; an output transfer on a cycle with o_val=1 and i_rdy=1.
REQ-005 FSM states SHALL be IDLE, DATA and APPEND.
REQ-006 IDLE: o_rdy=1, o_val=i_val&i_sop, o_rdy=i_rdy when i_sop=1; a word with i_val=1, i_sop=0 SHALL be consumed, dropped and pulse o_err.
REQ-007 IDLE, transfer with i_sop=1: acc <= calc(INIT, word); next state DATA, or APPEND if i_eop=1 in the same word.
REQ-008 DATA: o_dat/o_val/o_sop pass through combinationally from input (zero latency), o_eop=0, o_rdy=i_rdy; each transfer acc <= calc(acc, word); i_eop transfer -> APPEND.
REQ-009 DATA, transfer with i_sop=1: acc <= calc(INIT, word), o_err pulses, word forwarded with o_sop=1, state remains DATA (or APPEND if i_eop=1).
REQ-010 APPEND: o_rdy=0, o_val=1, o_sop=0; emits N=CRCWIDTH/DATAWIDTH words of final CRC F=(REFOUT ? reverse(acc) : acc) ^ XOROUT, most-significant word first.
REQ-011 APPEND word index counter SHALL advance only on output transfer; o_eop=1 on word N-1; its transfer -> IDLE, counter cleared.
REQ-012 i_rdy=0 in any state SHALL hold o_dat/o_val/o_eop stable and leave acc and counter unchanged.
REQ-013 Back-to-back packets: sop may be accepted in IDLE the cycle after the final CRC word transfer; no extra bubble.

Reset
REQ-014 reset=0 SHALL asynchronously force state IDLE, acc=INIT, counter=0, o_err=0; mid-packet or mid-APPEND data is discarded with no CRC emitted.
REQ-015 While in reset, o_val=0, o_sop=0, o_eop=0, o_rdy=0; o_dat don't-care but SHALL not be X-driven into o_val.

Verification
REQ-016 Default params, packet "123456789" (0x31..0x39), i_rdy=1 -> 9 data words unchanged then 0xBB, 0x3D with o_eop on 0x3D (CRC-16/ARC).
REQ-017 REFIN=0, REFOUT=0, same packet -> appended 0xFE, 0xE8 (CRC-16/BUYPASS).
REQ-018 Single-word packet 0x00 with sop=eop=1 -> output 0x00 (o_sop=1, o_eop=0), 0x00, 0x00 with o_eop on last.
REQ-019 Random i_rdy deassertion during "123456789" -> identical output sequence, no lost/duplicated words, o_rdy=0 throughout APPEND.
REQ-020 Word with i_sop=0 in IDLE -> dropped, o_err one cycle; sop mid-packet -> o_err, CRC restarts, subsequent "123456789" still yields 0xBB3D.
REQ-021 reset=0 asserted during APPEND after 0xBB sent -> o_val=0 immediately; next packet "123456789" yields 0xBB3D.
